// File: rtl/lcd_fifo_writer_if.sv
// Bundle of the FIFO read-side pins and the HD44780 parallel-bus pads
// driven by lcd_fifo_writer. The writer uses the master modport; the
// FIFO / pad model on the other side uses the slave modport.
interface lcd_fifo_writer_if;
  logic       fifo_empty;
  logic [8:0] fifo_data;
  logic       fifo_rd;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_d;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd,
    output lcd_rs,
    output lcd_rw,
    output lcd_e,
    output lcd_d
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd,
    input  lcd_rs,
    input  lcd_rw,
    input  lcd_e,
    input  lcd_d
  );
endinterface

// File: rtl/lcd_fifo_writer.sv
// lcd_fifo_writer: read side of the LCD command/data FIFO.
// Pops one 9-bit word (bit8 = RS, bits7:0 = payload) and plays it onto an
// HD44780-style bus with programmable setup / E-high / hold / execution
// wait. Clear and home commands (RS=0, payload 0x01..0x03) get the long
// execution wait.
// Optional feature: define LCD_NIBBLE_MODE_EN for the 4-bit bus, where each
// word is sent high nibble first on lcd_d[7:4] with lcd_d[3:0] held at 0.
// All outputs come straight from flops; reset is synchronous, active-high.
module lcd_fifo_writer #(
  parameter int SETUP_CYC    = 3,
  parameter int E_HIGH_CYC   = 23,
  parameter int HOLD_CYC     = 2,
  parameter int EXEC_CYC     = 1850,
  parameter int CLR_EXEC_CYC = 76000,
  parameter int CNT_W        = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  lcd_fifo_writer_if.master   bus,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SETUP,
    EHIGH,
    HOLD,
    WAIT
  } state_t;

  // Phase counters load N-1 on entry and the phase ends when they reach 0,
  // so every phase lasts exactly N clocks.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [8:0]       word;
  logic [8:0]       word_next;
  logic             rs_q;
  logic             rs_next;
  logic [7:0]       d_q;
  logic [7:0]       d_next;
  logic             fifo_rd_q;
  logic             lcd_e_q;
  logic             busy_q;
  logic             is_clr_word;
  logic [CNT_W-1:0] wait_ld;
`ifdef LCD_NIBBLE_MODE_EN
  logic             low_half;
  logic             low_half_next;
`endif

  // Clear display / return home need the long execution wait.
  assign is_clr_word = !word[8] &&
                       ((word[7:0] == 8'h01) ||
                        (word[7:0] == 8'h02) ||
                        (word[7:0] == 8'h03));
  assign wait_ld     = is_clr_word ? CLR_LD : EXEC_LD;

  assign bus.fifo_rd = fifo_rd_q;
  assign bus.lcd_rs  = rs_q;
  assign bus.lcd_rw  = 1'b0;
  assign bus.lcd_e   = lcd_e_q;
  assign bus.lcd_d   = d_q;
  assign busy        = busy_q;

  // Next-state, phase counter and bus value selection; everything holds by default.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    word_next  = word;
    rs_next    = rs_q;
    d_next     = d_q;
`ifdef LCD_NIBBLE_MODE_EN
    low_half_next = low_half;
`endif
    case (state)
      IDLE: begin
        if (en && !bus.fifo_empty) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = LOAD;
      end
      LOAD: begin
        word_next = bus.fifo_data;
        rs_next   = bus.fifo_data[8];
`ifdef LCD_NIBBLE_MODE_EN
        d_next        = {bus.fifo_data[7:4], 4'h0};
        low_half_next = 1'b0;
`else
        d_next    = bus.fifo_data[7:0];
`endif
        cnt_next   = SETUP_LD;
        state_next = SETUP;
      end
      SETUP: begin
        if (cnt == '0) begin
          cnt_next   = EHIGH_LD;
          state_next = EHIGH;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      EHIGH: begin
        if (cnt == '0) begin
          cnt_next   = HOLD_LD;
          state_next = HOLD;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
`ifdef LCD_NIBBLE_MODE_EN
          if (!low_half) begin
            low_half_next = 1'b1;
            d_next        = {word[3:0], 4'h0};
            cnt_next      = SETUP_LD;
            state_next    = SETUP;
          end else begin
            cnt_next   = wait_ld;
            state_next = WAIT;
          end
`else
          cnt_next   = wait_ld;
          state_next = WAIT;
`endif
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, datapath and output flops; outputs are decoded from the next
  // state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      word      <= '0;
      rs_q      <= 1'b0;
      d_q       <= '0;
      fifo_rd_q <= 1'b0;
      lcd_e_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef LCD_NIBBLE_MODE_EN
      low_half  <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      word      <= word_next;
      rs_q      <= rs_next;
      d_q       <= d_next;
      fifo_rd_q <= (state_next == FETCH);
      lcd_e_q   <= (state_next == EHIGH);
      busy_q    <= (state_next != IDLE);
`ifdef LCD_NIBBLE_MODE_EN
      low_half  <= low_half_next;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_fifo_writer.sv
// Testbench for lcd_fifo_writer. A bench FIFO feeds the DUT; a word-level
// model predicts every output from the word start time and its period.
module tb_lcd_fifo_writer;

  localparam int S   = 2;
  localparam int E   = 3;
  localparam int H   = 1;
  localparam int EX  = 5;
  localparam int CLR = 20;
`ifdef LCD_NIBBLE_MODE_EN
  localparam bit NIB = 1'b1;
`else
  localparam bit NIB = 1'b0;
`endif
  localparam int PASSES = NIB ? 2 : 1;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic en       = 1'b1;
  logic busy;
  bit   check_en = 1'b0;

  lcd_fifo_writer_if bus();

  always #5 clk = ~clk;

  lcd_fifo_writer #(
    .SETUP_CYC    (S),
    .E_HIGH_CYC   (E),
    .HOLD_CYC     (H),
    .EXEC_CYC     (EX),
    .CLR_EXEC_CYC (CLR),
    .CNT_W        (17)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .bus   (bus),
    .busy  (busy)
  );

  // Bench FIFO: words written by the stimulus, popped by fifo_rd, data valid next cycle.
  logic [8:0] fifo_mem [0:63];
  int         push_cnt = 0;
  int         pop_cnt  = 0;
  logic [8:0] data_q   = '0;

  assign bus.fifo_empty = (push_cnt == pop_cnt);
  assign bus.fifo_data  = data_q;

  always @(posedge clk) begin
    if (bus.fifo_rd && (pop_cnt < push_cnt)) begin
      data_q  <= fifo_mem[pop_cnt];
      pop_cnt <= pop_cnt + 1;
    end
  end

  // Word-level model: a word occupies wordPeriod() clocks starting at its fetch.
  function automatic int wordPeriod(input logic [8:0] w);
    int waitCyc;
    waitCyc = (!w[8] && (w[7:0] >= 8'd1) && (w[7:0] <= 8'd3)) ? CLR : EX;
    return 2 + PASSES * (S + E + H) + waitCyc;
  endfunction

  function automatic bit ePulseAt(input int off);
    return ((off >= 2 + S) && (off < 2 + S + E)) ||
           (NIB && (off >= 2 + 2 * S + E + H) && (off < 2 + 2 * S + 2 * E + H));
  endfunction

  function automatic logic [7:0] lastD(input logic [8:0] w);
    return NIB ? {w[3:0], 4'h0} : w[7:0];
  endfunction

  bit         m_act = 1'b0;
  int         m_off = 0;
  int         m_per = 0;
  int         m_idx = 0;
  logic [8:0] m_word = '0;
  logic       exp_rd = 1'b0;
  logic       exp_busy = 1'b0;
  logic       exp_e = 1'b0;
  logic       exp_rs = 1'b0;
  logic [7:0] exp_d = '0;

  // Advance the model one clock using the inputs seen just before the edge.
  always @(posedge clk) begin
    if (reset) begin
      m_act = 1'b0;
      m_off = 0;
      exp_d = '0;
      exp_rs = 1'b0;
    end else if (m_act) begin
      m_off = m_off + 1;
      if (m_off >= m_per) m_act = 1'b0;
    end else if (en && (m_idx < push_cnt)) begin
      m_act  = 1'b1;
      m_off  = 0;
      m_word = fifo_mem[m_idx];
      m_idx  = m_idx + 1;
      m_per  = wordPeriod(m_word);
    end
    if (m_act && (m_off == 2)) begin
      exp_rs = m_word[8];
      exp_d  = NIB ? {m_word[7:4], 4'h0} : m_word[7:0];
    end
    if (m_act && NIB && (m_off == 2 + S + E + H)) begin
      exp_d = {m_word[3:0], 4'h0};
    end
    exp_rd   = m_act && (m_off == 0);
    exp_busy = m_act;
    exp_e    = m_act && ePulseAt(m_off);
  end

  // Activity monitor used by the hand-computed expectations.
  int         cyc = 0;
  int         rd_total = 0;
  int         busy_total = 0;
  int         e_total = 0;
  int         er_total = 0;
  int         rd_log [0:63];
  int         er_log [0:63];
  logic [7:0] er_d   [0:63];
  logic       prev_e = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (check_en) begin
      if (bus.fifo_rd === 1'b1) begin
        if (rd_total < 64) rd_log[rd_total] = cyc;
        rd_total = rd_total + 1;
      end
      if (busy === 1'b1) busy_total = busy_total + 1;
      if (bus.lcd_e === 1'b1) e_total = e_total + 1;
      if ((bus.lcd_e === 1'b1) && !prev_e) begin
        if (er_total < 64) begin
          er_log[er_total] = cyc;
          er_d[er_total]   = bus.lcd_d;
        end
        er_total = er_total + 1;
      end
      prev_e = (bus.lcd_e === 1'b1);
    end
  end

  // Literal expectations posted by the stimulus, checked by the compare process.
  string       lit_name [0:63];
  logic [31:0] lit_act  [0:63];
  logic [31:0] lit_exp  [0:63];
  int          lit_wr = 0;
  int          lit_rd = 0;

  task automatic expectLit(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (lit_wr < 64) begin
      lit_name[lit_wr] = name;
      lit_act[lit_wr]  = act;
      lit_exp[lit_wr]  = exp;
      lit_wr = lit_wr + 1;
    end
  endtask

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (act !== exp) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Compare process: DUT against model every cycle, then any pending literals.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("fifo_rd", 32'(bus.fifo_rd), 32'(exp_rd));
      checkOutput("busy",    32'(busy),        32'(exp_busy));
      checkOutput("lcd_e",   32'(bus.lcd_e),   32'(exp_e));
      checkOutput("lcd_rs",  32'(bus.lcd_rs),  32'(exp_rs));
      checkOutput("lcd_rw",  32'(bus.lcd_rw),  32'd0);
      checkOutput("lcd_d",   32'(bus.lcd_d),   32'(exp_d));
    end
    while (lit_rd < lit_wr) begin
      checkOutput(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
      lit_rd = lit_rd + 1;
    end
  end

  task automatic applyStimulus(input logic [8:0] w);
    fifo_mem[push_cnt] = w;
    push_cnt = push_cnt + 1;
  endtask

  int rd0, busy0, e0, er0;

  task automatic snap();
    @(posedge clk);
    rd0   = rd_total;
    busy0 = busy_total;
    e0    = e_total;
    er0   = er_total;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit seen;
    @(posedge clk);
    check_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: empty FIFO with en=1 must stay idle.
    snap();
    repeat (50) @(negedge clk);
    expectLit("t1_lcd_e", 32'(bus.lcd_e), 32'd0);
    expectLit("t1_lcd_d", 32'(bus.lcd_d), 32'd0);
    expectLit("t1_busy", 32'(busy), 32'd0);
    @(posedge clk);
    expectLit("t1_rd_count", 32'(rd_total - rd0), 32'd0);

    // 2: single data byte.
    snap();
    @(negedge clk);
    applyStimulus(9'h141);
    repeat (28) @(negedge clk);
    expectLit("t2_lcd_d", 32'(bus.lcd_d), 32'(lastD(9'h141)));
    expectLit("t2_lcd_rs", 32'(bus.lcd_rs), 32'd1);
    @(posedge clk);
    expectLit("t2_rd_count", 32'(rd_total - rd0), 32'd1);
    expectLit("t2_busy_len", 32'(busy_total - busy0), NIB ? 32'd19 : 32'd13);
    expectLit("t2_e_len", 32'(e_total - e0), NIB ? 32'd6 : 32'd3);
    expectLit("t2_e_latency", 32'(er_log[er0] - rd_log[rd0]), 32'd4);
    expectLit("t2_d_at_e", 32'(er_d[er0]), NIB ? 32'h40 : 32'h41);

    // 3: clear display uses the long wait.
    snap();
    @(negedge clk);
    applyStimulus(9'h001);
    repeat (45) @(negedge clk);
    expectLit("t3_lcd_rs", 32'(bus.lcd_rs), 32'd0);
    expectLit("t3_lcd_d", 32'(bus.lcd_d), 32'(lastD(9'h001)));
    @(posedge clk);
    expectLit("t3_rd_count", 32'(rd_total - rd0), 32'd1);
    expectLit("t3_busy_len", 32'(busy_total - busy0), NIB ? 32'd34 : 32'd28);

    // 4: three words back-to-back.
    snap();
    @(negedge clk);
    applyStimulus(9'h148);
    applyStimulus(9'h149);
    applyStimulus(9'h080);
    repeat (NIB ? 70 : 50) @(negedge clk);
    expectLit("t4_lcd_d", 32'(bus.lcd_d), 32'(lastD(9'h080)));
    expectLit("t4_lcd_rs", 32'(bus.lcd_rs), 32'd0);
    @(posedge clk);
    expectLit("t4_rd_count", 32'(rd_total - rd0), 32'd3);
    expectLit("t4_gap1", 32'(rd_log[rd0 + 1] - rd_log[rd0]), NIB ? 32'd20 : 32'd14);
    expectLit("t4_gap2", 32'(rd_log[rd0 + 2] - rd_log[rd0 + 1]), NIB ? 32'd20 : 32'd14);
    expectLit("t4_d_order", 32'(er_d[er0 + PASSES]), NIB ? 32'h40 : 32'h49);

    // 5: reset while E is high abandons the word.
    @(negedge clk);
    applyStimulus(9'h155);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.lcd_e === 1'b1) seen = 1'b1;
    end
    expectLit("t5_e_seen", 32'(seen), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    expectLit("t5_lcd_e", 32'(bus.lcd_e), 32'd0);
    expectLit("t5_busy", 32'(busy), 32'd0);
    expectLit("t5_lcd_d", 32'(bus.lcd_d), 32'd0);
    reset = 1'b0;
    snap();
    repeat (20) @(negedge clk);
    @(posedge clk);
    expectLit("t5_no_retry", 32'(rd_total - rd0), 32'd0);
    @(negedge clk);
    applyStimulus(9'h133);
    repeat (25) @(negedge clk);
    expectLit("t5_resume_d", 32'(bus.lcd_d), 32'(lastD(9'h133)));
    @(posedge clk);
    expectLit("t5_resume_rd", 32'(rd_total - rd0), 32'd1);

    // 6: en dropped during SETUP finishes the word, then holds off.
    snap();
    @(negedge clk);
    applyStimulus(9'h161);
    applyStimulus(9'h162);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.fifo_rd === 1'b1) seen = 1'b1;
    end
    expectLit("t6_rd_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (40) @(negedge clk);
    expectLit("t6_lcd_d", 32'(bus.lcd_d), 32'(lastD(9'h161)));
    expectLit("t6_busy", 32'(busy), 32'd0);
    @(posedge clk);
    expectLit("t6_rd_held", 32'(rd_total - rd0), 32'd1);
    @(negedge clk);
    en = 1'b1;
    repeat (30) @(negedge clk);
    expectLit("t6_lcd_d2", 32'(bus.lcd_d), 32'(lastD(9'h162)));
    @(posedge clk);
    expectLit("t6_rd_total", 32'(rd_total - rd0), 32'd2);

`ifdef LCD_NIBBLE_MODE_EN
    // 7: nibble mode sends high then low nibble.
    snap();
    @(negedge clk);
    applyStimulus(9'h1A5);
    repeat (30) @(negedge clk);
    @(posedge clk);
    expectLit("t7_busy_len", 32'(busy_total - busy0), 32'd19);
    expectLit("t7_e_pulses", 32'(er_total - er0), 32'd2);
    expectLit("t7_d_first", 32'(er_d[er0]), 32'hA0);
    expectLit("t7_d_second", 32'(er_d[er0 + 1]), 32'h50);
`endif

    repeat (3) @(negedge clk);
    for (int i = 0; i < 10 && (lit_rd < lit_wr); i++) @(negedge clk);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
